// File: rtl/multu_seq_if.sv
// Handshake and operand bundle between the EX-stage control and the sequential
// multiplier. The master side (pipeline control) issues operands and start/flush.
// The slave side (multu_seq) returns busy, done and the 64-bit product.
interface multu_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 flush;
    logic                 is_signed;
    logic [WIDTH-1:0]     dataA;
    logic [WIDTH-1:0]     dataB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, flush, is_signed, dataA, dataB,
        input  busy, done, product
    );

    modport slave (
        input  start, flush, is_signed, dataA, dataB,
        output busy, done, product
    );
endinterface

// File: rtl/multu_seq.sv
// multu_seq: radix-2 shift-add 32x32 multiplier for the MIPS EX stage.
// A start in IDLE/DONE launches a 32-iteration run. The 64-bit product is
// loaded at the completing edge and held until the next completion.
// Optional feature macro: MULTU_SIGNED_EN enables signed (MULT) support.
// With that macro, operands are converted to magnitudes at start and the
// result is negated at completion. Without it, is_signed is ignored.
module multu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    multu_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;    // multiplicand (magnitude in signed mode)
    logic [WIDTH-1:0]   r_hi;       // upper half of the accumulator
    logic [WIDTH-1:0]   r_lo;       // lower half; starts as the multiplier
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic [2*WIDTH-1:0] w_full;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_a_load;
    logic [WIDTH-1:0]   w_b_load;

`ifdef MULTU_SIGNED_EN
    logic               r_neg;
    logic               w_neg_load;

    // Operand conditioning: magnitudes and the sign of the product in MULT mode.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        w_a_load   = bus.dataA;
        w_b_load   = bus.dataB;
        w_neg_load = 1'b0;
        if (bus.is_signed) begin
            if (bus.dataA[WIDTH-1]) w_a_load = -bus.dataA;
            if (bus.dataB[WIDTH-1]) w_b_load = -bus.dataB;
            w_neg_load = bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1];
        end
    end
`else
    assign w_a_load = bus.dataA;
    assign w_b_load = bus.dataB;
`endif

    // One shift-add step: conditional WIDTH+1-bit add into the upper half, then shift right.
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_hi_next = w_sum[WIDTH:1];
        w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
        w_full    = {w_hi_next, w_lo_next};
`ifdef MULTU_SIGNED_EN
        w_result  = r_neg ? -w_full : w_full;
`else
        w_result  = w_full;
`endif
    end

    // Control FSM and datapath registers, with registered busy/done/product.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
`ifdef MULTU_SIGNED_EN
            r_neg     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // start beats flush here; flush has no meaning outside RUN
                    if (bus.start) begin
                        r_mcand <= w_a_load;
                        r_lo    <= w_b_load;
                        r_hi    <= '0;
                        r_cnt   <= '0;
`ifdef MULTU_SIGNED_EN
                        r_neg   <= w_neg_load;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // a new start during RUN is dropped, never queued
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_hi_next;
                        r_lo  <= w_lo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_product <= w_result;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: doc/multu_seq.md
# multu_seq

Sequential 32x32 multiplier for the EX stage of the five-stage MIPS pipeline. Accepts the forwarded operands (post-AMUX/BMUX values) on a start pulse, computes the 64-bit product with a radix-2 shift-add datapath over 32 cycles, and delivers it with a one-cycle done pulse to the HiLo register pair downstream. `busy` drives the pipeline stall/hold logic while a multiply is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- flush  input  1  synchronous abort of an in-flight multiply.
- is_signed  input  1  1 = MULT (signed), 0 = MULTU; sampled with start.
- dataA  input  WIDTH  multiplicand (forwarded rs value).
- dataB  input  WIDTH  multiplier (forwarded rt value).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is newly valid.
- product  output  2*WIDTH  last completed result, held until the next completion.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + start=1: latch operands (magnitudes if signed mode is active, see Configuration), latch negate flag, clear accumulator, count=0, go to RUN.
- IDLE/DONE + start=0: go to IDLE.
- RUN: each cycle, if multiplier LSB is 1, add the multiplicand to the upper half of the accumulator (WIDTH+1-bit add, carry kept), then shift the accumulator right 1; count increments.
- RUN with count==WIDTH-1: perform the final iteration, load product (two's-complement negated if negate flag is set), go to DONE.
- DONE: done=1 for exactly this cycle; next state is as for IDLE.
- start while in RUN: ignored; not queued.
- flush in RUN: go to IDLE at that edge; no done; product unchanged. flush in IDLE/DONE has no effect. If flush and start are both high in IDLE/DONE, start wins.
- rst at any time, including mid-RUN: state IDLE, busy=0, done=0, product=0, count=0, internal registers cleared.
- Width rule: the product is exact modulo 2^(2*WIDTH); there is no overflow indication.

## Timing
- Reset values: busy=0, done=0, product=0.
- Edge E0 accepts start. busy=1 from E0 through E32 (32 cycles). At E32, product updates and done=1 for the cycle following E32. busy=0 in that cycle.
- Latency: start edge to product valid = 32 clocks. Back-to-back throughput: start accepted in the DONE cycle gives a new multiply every 33 clocks.
- product changes only at the completing edge or on rst. It is stable at all other times, including during a subsequent RUN.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- MULTU_SIGNED_EN defined: is_signed=1 operands are converted to absolute values at start. The negate flag equals dataA[WIDTH-1]^dataB[WIDTH-1], and the result is negated at completion. Latency is unchanged.
- MULTU_SIGNED_EN undefined: is_signed is ignored and all multiplies are unsigned. The abs/negate logic is not synthesized.

## Test plan
- Reset, then start with A=3, B=5, unsigned -> busy high for 32 cycles. done pulses 32 clocks after the start edge with product=0x0000_0000_0000_000F.
- A=0xFFFFFFFF, B=0xFFFFFFFF, unsigned -> product=0xFFFFFFFE_00000001. Issue a second start (A=2, B=7) in the DONE cycle -> accepted, and 0x...0E arrives 32 clocks later.
- Start A=6, B=7, then pulse start again with A=1, B=1 at cycle 10 -> ignored. Result is 0x2A at cycle 32.
- After a result of 0x2A, start A=9, B=9, then assert flush at cycle 10 -> busy drops next cycle, no done, product stays 0x2A. Repeat with rst at cycle 10 -> product=0, busy=0.
- A=0xFFFFFFFD (-3), B=5, is_signed=1: with MULTU_SIGNED_EN -> 0xFFFFFFFF_FFFFFFF1. Without it -> 0x00000004_FFFFFFF1. Also, with the macro, (-4)x(-4) -> 0x0000_0000_0000_0010.
